uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (uart_tx AXI-stream byte input) between NREQ requesters,
//  e.g. CPU port logic and a debug monitor. Grants are per packet: a requester keeps the

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-packet arbiter that shares one uart_tx byte stream among NREQ requesters.
// Optional macro UART_ARB_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     grant,
   output logic [7:0]          tx_tdata,
   output logic                tx_tvalid,
   input  logic                tx_tready,
   output logic                timeout_ev
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [TW-1:0] TLAST     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state, state_nxt;
   logic [NREQ-1:0] grant_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   last_owner, last_owner_nxt;
   logic [IW-1:0]   pick;
   logic [TW-1:0]   idle_cnt, idle_cnt_nxt;
   logic            timeout_nxt;
   logic            valid_g, last_g, room, accept, found;
   logic [7:0]      data_g;

   always_comb begin
      valid_g = 1'b0;
      last_g  = 1'b0;
      data_g  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            valid_g = req_valid[i];
            last_g  = req_last[i];
            data_g  = req_data[8*i +: 8];
         end
      end
   end

   // Winner search: first valid index above last_owner, otherwise wrap to the lowest valid index.
   always_comb begin
      pick  = last_owner;
      found = 1'b0;
`ifdef UART_ARB_PRIO_EN
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            pick  = IW'(i);
            found = 1'b1;
         end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (IW'(i) > last_owner)) begin
            pick  = IW'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            pick  = IW'(i);
            found = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      idle_cnt_nxt   = idle_cnt;
      timeout_nxt    = 1'b0;
      room           = ~tx_tvalid | tx_tready;
      accept         = 1'b0;
      req_ready      = '0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_nxt    = LOCK;
               grant_nxt    = NREQ'(1) << pick;
               owner_nxt    = pick;
               idle_cnt_nxt = '0;
            end
         end
         LOCK: begin
            req_ready = room ? grant : '0;
            accept    = valid_g & room;
            if (accept) begin
               idle_cnt_nxt = '0;
               if (last_g) begin
                  state_nxt      = IDLE;
                  grant_nxt      = '0;
                  last_owner_nxt = owner;
               end
            end else if (!valid_g && (TIMEOUT > 0)) begin
               // Expiry needs valid low, so a same-cycle accept always wins.
               if (idle_cnt == TLAST) begin
                  state_nxt      = IDLE;
                  grant_nxt      = '0;
                  last_owner_nxt = owner;
                  idle_cnt_nxt   = '0;
                  timeout_nxt    = 1'b1;
               end else begin
                  idle_cnt_nxt = idle_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         owner      <= '0;
         last_owner <= LAST_INIT;
         idle_cnt   <= '0;
         timeout_ev <= 1'b0;
         tx_tdata   <= '0;
         tx_tvalid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         idle_cnt   <= idle_cnt_nxt;
         timeout_ev <= timeout_nxt;
         if (accept) begin
            tx_tdata  <= data_g;
            tx_tvalid <= 1'b1;
         end else if (tx_tready) begin
            tx_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (NREQ=2, TIMEOUT=16).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [1:0]  grant;
   logic [7:0]  tx_tdata;
   logic        tx_tvalid;
   logic        tx_tready;
   logic        timeout_ev;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.NREQ(2), .TIMEOUT(16), .TW(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .grant      (grant),
      .tx_tdata   (tx_tdata),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .timeout_ev (timeout_ev)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_tready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      checks++;
      if ({grant, req_ready, tx_tvalid, tx_tdata, timeout_ev} !== 14'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got grant=%b ready=%b tvalid=%b tdata=%h tev=%b, expected all zero",
                  grant, req_ready, tx_tvalid, tx_tdata, timeout_ev);
      end
   endtask

   task automatic test_basic_packet;
      do_reset();
      req_valid = 2'b01; req_data[7:0] = 8'h41; req_last = 2'b00;
      #1;
      checks++;
      if (grant !== 2'b00) begin errors++; $display("[TB] FAIL basic_grant_c0: got %b expected 00", grant); end
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("[TB] FAIL basic_grant_c1: got %b expected 01", grant); end
      checks++;
      if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_tvalid_c1: got %b expected 0", tx_tvalid); end
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL basic_ready_c1: got %b expected 01", req_ready); end
      tick();
      checks++;
      if ({tx_tvalid, tx_tdata} !== {1'b1, 8'h41}) begin errors++; $display("[TB] FAIL basic_data_c2: got v=%b d=%h expected v=1 d=41", tx_tvalid, tx_tdata); end
      req_data[7:0] = 8'h42;
      tick();
      checks++;
      if ({tx_tvalid, tx_tdata} !== {1'b1, 8'h42}) begin errors++; $display("[TB] FAIL basic_data_c3: got v=%b d=%h expected v=1 d=42", tx_tvalid, tx_tdata); end
      req_data[7:0] = 8'h43; req_last = 2'b01;
      tick();
      checks++;
      if ({tx_tvalid, tx_tdata} !== {1'b1, 8'h43}) begin errors++; $display("[TB] FAIL basic_data_c4: got v=%b d=%h expected v=1 d=43", tx_tvalid, tx_tdata); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("[TB] FAIL basic_release_c4: got %b expected 00", grant); end
      req_valid = 2'b00; req_last = 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL basic_ready_c4: got %b expected 00", req_ready); end
      tick();
      checks++;
      if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain_c5: got %b expected 0", tx_tvalid); end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_grant;
      logic [7:0] exp_data;
      do_reset();
      req_valid = 2'b11; req_last = 2'b11; req_data = {8'hB1, 8'hA0};
      for (int p = 0; p < 4; p++) begin
`ifdef UART_ARB_PRIO_EN
         exp_grant = 2'b01;
`else
         exp_grant = (p % 2 == 0) ? 2'b01 : 2'b10;
`endif
         exp_data = (exp_grant == 2'b01) ? 8'hA0 : 8'hB1;
         tick();
         checks++;
         if (grant !== exp_grant) begin errors++; $display("[TB] FAIL rr_grant_p%0d: got %b expected %b", p, grant, exp_grant); end
         tick();
         checks++;
         if ({grant, tx_tvalid, tx_tdata} !== {2'b00, 1'b1, exp_data})
            begin errors++; $display("[TB] FAIL rr_data_p%0d: got grant=%b v=%b d=%h expected grant=00 v=1 d=%h", p, grant, tx_tvalid, tx_tdata, exp_data); end
      end
      req_valid = 2'b00; req_last = 2'b00;
   endtask

   task automatic test_stall;
      logic [7:0] bytes [0:2];
      logic [7:0] rec [0:7];
      int idx;
      int nrec;
      bytes[0] = 8'h10; bytes[1] = 8'h11; bytes[2] = 8'h12;
      idx = 0; nrec = 0;
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc > 0) tick();
         tx_tready     = !(cyc >= 3 && cyc < 23);
         req_valid     = {1'b0, idx < 3};
         req_data[7:0] = bytes[(idx < 3) ? idx : 0];
         req_last      = {1'b0, idx == 2};
         #1;
         if (cyc >= 3 && cyc < 23) begin
            checks++;
            if ({tx_tvalid, tx_tdata, req_ready} !== {1'b1, 8'h11, 2'b00})
               begin errors++; $display("[TB] FAIL stall_c%0d: got v=%b d=%h ready=%b expected v=1 d=11 ready=00", cyc, tx_tvalid, tx_tdata, req_ready); end
         end
         if (tx_tvalid && tx_tready) begin
            if (nrec < 8) rec[nrec] = tx_tdata;
            nrec++;
         end
         if (req_valid[0] && req_ready[0]) idx++;
      end
      checks++;
      if (nrec !== 3) begin errors++; $display("[TB] FAIL stall_count: got %0d bytes expected 3", nrec); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (k < nrec && rec[k] !== bytes[k]) begin errors++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", k, rec[k], bytes[k]); end
      end
   endtask

   task automatic test_timeout;
      do_reset();
      req_valid = 2'b01; req_data = {8'h66, 8'h55}; req_last = 2'b00;
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("[TB] FAIL to_grant_c1: got %b expected 01", grant); end
      tick();
      checks++;
      if ({tx_tvalid, tx_tdata} !== {1'b1, 8'h55}) begin errors++; $display("[TB] FAIL to_data_c2: got v=%b d=%h expected v=1 d=55", tx_tvalid, tx_tdata); end
      req_valid = 2'b10; req_last = 2'b10;
      for (int c = 3; c <= 17; c++) begin
         tick();
         checks++;
         if ({grant, timeout_ev} !== {2'b01, 1'b0})
            begin errors++; $display("[TB] FAIL to_hold_c%0d: got grant=%b tev=%b expected grant=01 tev=0", c, grant, timeout_ev); end
      end
      tick();
      checks++;
      if ({grant, timeout_ev} !== {2'b00, 1'b1}) begin errors++; $display("[TB] FAIL to_release_c18: got grant=%b tev=%b expected grant=00 tev=1", grant, timeout_ev); end
      tick();
      checks++;
      if ({grant, timeout_ev} !== {2'b10, 1'b0}) begin errors++; $display("[TB] FAIL to_next_c19: got grant=%b tev=%b expected grant=10 tev=0", grant, timeout_ev); end
      req_valid = 2'b00; req_last = 2'b00;
   endtask

   task automatic test_reset_mid_packet;
      do_reset();
      tx_tready = 1'b0;
      req_valid = 2'b01; req_data[7:0] = 8'h77; req_last = 2'b00;
      tick();
      tick();
      checks++;
      if ({tx_tvalid, tx_tdata} !== {1'b1, 8'h77}) begin errors++; $display("[TB] FAIL rmid_data_c2: got v=%b d=%h expected v=1 d=77", tx_tvalid, tx_tdata); end
      rst = 1'b0;
      tick();
      #1;
      checks++;
      if ({grant, req_ready, tx_tvalid, tx_tdata, timeout_ev} !== 14'd0)
         begin errors++; $display("[TB] FAIL rmid_outputs: got grant=%b ready=%b v=%b d=%h tev=%b expected all zero", grant, req_ready, tx_tvalid, tx_tdata, timeout_ev); end
      rst = 1'b1; req_valid = 2'b11; req_last = 2'b11; tx_tready = 1'b1;
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("[TB] FAIL rmid_first_grant: got %b expected 01", grant); end
      req_valid = 2'b00; req_last = 2'b00;
   endtask

   task automatic test_accept_at_timeout;
      do_reset();
      req_valid = 2'b01; req_data[7:0] = 8'h88; req_last = 2'b00;
      tick();
      tick();
      req_valid = 2'b00;
      repeat (15) tick();
      checks++;
      if ({grant, timeout_ev} !== {2'b01, 1'b0}) begin errors++; $display("[TB] FAIL edge_hold_c17: got grant=%b tev=%b expected grant=01 tev=0", grant, timeout_ev); end
      req_valid = 2'b01; req_data[7:0] = 8'h99;
      tick();
      checks++;
      if ({grant, timeout_ev, tx_tdata} !== {2'b01, 1'b0, 8'h99})
         begin errors++; $display("[TB] FAIL edge_accept_c18: got grant=%b tev=%b d=%h expected grant=01 tev=0 d=99", grant, timeout_ev, tx_tdata); end
      req_data[7:0] = 8'h9A; req_last = 2'b01;
      tick();
      checks++;
      if ({grant, timeout_ev, tx_tdata} !== {2'b00, 1'b0, 8'h9A})
         begin errors++; $display("[TB] FAIL edge_last_c19: got grant=%b tev=%b d=%h expected grant=00 tev=0 d=9a", grant, timeout_ev, tx_tdata); end
      req_valid = 2'b00; req_last = 2'b00;
   endtask

   initial begin
      test_reset();
      test_basic_packet();
      test_round_robin();
      test_stall();
      test_timeout();
      test_reset_mid_packet();
      test_accept_at_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
